spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
Receive front-end of the SPI slave. Oversamples the external quad-capable SPI bus (sclk, cs_n, mosi[3:0]) in the system clock domain and deserializes 1-, 2- or 4-lane MOSI traffic into bytes. Bytes are queued in a small FIFO and presented on a valid/ready byte stream to the slave command decoder. Also reports frame boundaries and errors.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (>=2)

Ports:
clk  input  1  system clock; must be >= 8x sclk frequency
rst_n  input  1  asynchronous active-low reset
cfg_lanes  input  2  0: 1 lane, 1: 2 lanes, 2: 4 lanes, 3: treated as 4 lanes
sclk  input  1  SPI clock, idle low, async to clk
cs_n  input  1  SPI chip select, active low, async
mosi  input  4  SPI data lanes, async; unused lanes ignored
m_data  output  8  received byte
m_first  output  1  byte is first of its frame
m_valid  output  1  byte available
m_ready  input  1  consumer accepts byte when m_valid&m_ready
frame_done  output  1  1-cycle pulse on frame end (cs_n rise)
partial_err  output  1  1-cycle pulse: frame ended mid-byte
overflow  output  1  1-cycle pulse: completed byte dropped, FIFO full
busy  output  1  high while state is ACTIVE

Behaviour:
- Reset: all flops cleared; m_valid, m_first, frame_done, partial_err, overflow, busy = 0; m_data = 0; FIFO empty; state = SKIP.
- Sync: sclk, cs_n, mosi each pass SYNC_STAGES flops (reset 0). sclk_rise = synced sclk 1 and previous synced sclk 0. Same for cs_fall/cs_rise on synced cs_n.
- States:
  SKIP: wait for synced cs_n = 1, then IDLE. Prevents joining a frame already in progress at reset.
  IDLE: on cs_fall -> ACTIVE; latch cfg_lanes into lanes_q, clear bit_cnt (3 bits) and shift reg, set first_pend = 1.
  ACTIVE: busy = 1. On sclk_rise, sample synced mosi. On cs_rise -> IDLE, with frame_done pulse. If bit_cnt != 0, also pulse partial_err and discard the partial byte.
- cfg_lanes is read only at cs_fall. Changes mid-frame have no effect.
- Bit order: LSB first. With L lanes, each sclk_rise delivers byte bits bit_cnt..bit_cnt+L-1, where mosi[j] maps to bit bit_cnt+j. bit_cnt += L (mod 8).
- Byte complete when bit_cnt wraps to 0. Push {first_pend, byte} into the FIFO at the end of the detecting cycle, then clear first_pend.
- Latency: m_valid rises SYNC_STAGES+2 clk after the sclk pin rising edge (empty FIFO).
- sclk_rise and cs_rise in the same cycle: process the sample first, then end the frame.
- FIFO: first-word-fall-through. m_data/m_first are valid only while m_valid = 1; hold stable while m_valid & !m_ready.
- Push while full: byte dropped and overflow pulses, unless a pop occurs in the same cycle, in which case the push is accepted.
- Pop while empty: ignored.
- Overflow does not disturb the frame or bit alignment.
- sclk edges while cs_n is high are ignored.
- Reset mid-frame: everything clears immediately; bits already received are lost; state SKIP until cs_n goes high.

Test Plan:
1. lanes=0, frame of bytes 0xA5, 0x3C (16 sclk, LSB first), m_ready=1 -> m_data 0xA5 m_first=1, then 0x3C m_first=0; one frame_done pulse; partial_err=0.
2. lanes=2, bytes 0x12, 0x34 (nibbles on edges: 2,1,4,3) -> 0x12 first=1, 0x34 first=0; 4 sclk edges total.
3. lanes=1, 12 bits (byte 0xC3 + 4 bits), cs_n rises -> only 0xC3 emitted; partial_err and frame_done pulse in the same cycle.
4. m_ready=0, FIFO_DEPTH=4, 6 bytes 0x01..0x06 -> overflow pulses twice; then m_ready=1 drains 0x01..0x04 in order, m_valid drops.
5. rst_n pulsed low after 3 of 8 bits with cs_n held low -> all outputs 0. Further sclk edges in that frame produce nothing. Next full frame (cs_n high then low) with 0x5A -> 0x5A first=1.
6. lanes=0 latched, cfg_lanes switched to 2 mid-frame -> byte 0x81 still decoded at 1 lane over 8 edges.

Source files
------------

// File: rtl/spi_slave_rx.sv
// Receive front-end of the SPI slave.
// Oversamples a quad-capable SPI bus in the system clock domain and assembles
// 1-, 2- or 4-lane MOSI traffic into bytes, LSB first. Completed bytes go into a
// first-word-fall-through FIFO that drives a valid/ready byte stream. The block
// also flags frame ends, frames that stop mid-byte, and bytes dropped on a full FIFO.
module spi_slave_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cfg_lanes,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] mosi,
    output logic [7:0] m_data,
    output logic       m_first,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_done,
    output logic       partial_err,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SKIP, IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0]      sclk_sync, cs_sync;
    logic [SYNC_STAGES-1:0][3:0] mosi_sync;
    logic                        sclk_s, cs_s, sclk_d, cs_d;
    logic [3:0]                  mosi_s;
    logic                        sclk_rise, cs_rise, cs_fall;

    state_t     state, state_nxt;
    logic       frame_start, frame_end, sample;

    logic [1:0] lanes_q;
    logic [2:0] bit_cnt, bit_cnt_nxt, step;
    logic [7:0] shreg, shreg_nxt;
    logic       first_pend;
    logic       done_q, done_first;
    logic [7:0] done_data;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          full, pop, push;

    // Synchronizer chains for the asynchronous SPI pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Previous synced levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SKIP;
        else        state <= state_nxt;
    end

    // Next-state logic; SKIP keeps us out of a frame already running at reset.
    always_comb begin
        state_nxt = state;
        case (state)
            SKIP:    if (cs_s)    state_nxt = IDLE;
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = SKIP;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy        = (state == ACTIVE);
        frame_start = (state == IDLE) & cs_fall;
        frame_end   = (state == ACTIVE) & cs_rise;
        sample      = (state == ACTIVE) & sclk_rise;
    end

    // Bits per sclk edge and the shift register as it looks after this sample.
    always_comb begin
        case (lanes_q)
            2'd0:    step = 3'd1;
            2'd1:    step = 3'd2;
            default: step = 3'd4;
        endcase
        bit_cnt_nxt = sample ? bit_cnt + step : bit_cnt;
        shreg_nxt   = shreg;
        for (int j = 0; j < 4; j++) begin
            if (3'(j) < step) shreg_nxt[bit_cnt + 3'(j)] = mosi_s[j];
        end
    end

    // Deserializer and frame bookkeeping. A sample landing together with cs_rise
    // is taken first, so partial_err looks at the post-sample bit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            first_pend  <= 1'b0;
            done_q      <= 1'b0;
            done_first  <= 1'b0;
            done_data   <= '0;
            frame_done  <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            done_q      <= sample && (bit_cnt_nxt == 3'd0);
            frame_done  <= frame_end;
            partial_err <= frame_end && (bit_cnt_nxt != 3'd0);
            if (frame_start) begin
                lanes_q    <= cfg_lanes;
                bit_cnt    <= '0;
                shreg      <= '0;
                first_pend <= 1'b1;
            end else if (sample) begin
                bit_cnt <= bit_cnt_nxt;
                shreg   <= shreg_nxt;
                if (bit_cnt_nxt == 3'd0) begin
                    done_data  <= shreg_nxt;
                    done_first <= first_pend;
                    first_pend <= 1'b0;
                end
            end
        end
    end

    // A push into a full FIFO still lands if the consumer pops in the same cycle.
    assign full = cnt[AW];
    assign pop  = m_valid & m_ready;
    assign push = done_q & (~full | pop);

    // Byte FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= done_q & full & ~pop;
            if (push) begin
                mem[wr_ptr] <= {done_first, done_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Fall-through head of the FIFO; outputs forced to zero when empty.
    always_comb begin
        m_valid = (cnt != '0);
        m_data  = m_valid ? mem[rd_ptr][7:0] : 8'h00;
        m_first = m_valid ? mem[rd_ptr][8]   : 1'b0;
    end

endmodule
